// File: rtl/rowaddr_issue_pipe.sv
// Row-address issue pipe: merges memShare row offsets with a per-layer base.
// Optional ROWADDR_BOUND_CHK_EN adds the addr_oob_o range flag.
module rowaddr_issue_pipe #(
  parameter int SHARED_BANK_NUM           = 5,
  parameter int GP1_ROW_ADDR_OFFSET_WIDTH = 1,
  parameter int GP2_ROW_ADDR_OFFSET_WIDTH = 2,
  parameter int MODE_BITWIDTH             = 3,
  parameter int ROW_ADDR_BITWIDTH         = 8,
  parameter int BEAT_ROW_STRIDE           = 4,
  parameter int BEATS_PER_LAYER           = 8,
  parameter int LAYER_NUM                 = 4,
  localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 rqst_valid_i,
  output logic                                 rqst_ready_o,
  input  logic [GP1_ROW_ADDR_OFFSET_WIDTH-1:0] rowAddr_offset0_i,
  input  logic [GP1_ROW_ADDR_OFFSET_WIDTH-1:0] rowAddr_offset1_i,
  input  logic [GP2_ROW_ADDR_OFFSET_WIDTH-1:0] rowAddr_offset2_i,
  input  logic [GP1_ROW_ADDR_OFFSET_WIDTH-1:0] rowAddr_offset3_i,
  input  logic [GP2_ROW_ADDR_OFFSET_WIDTH-1:0] rowAddr_offset4_i,
  input  logic [MODE_BITWIDTH-1:0]             modeSet_i,
  input  logic                                 layer_start_i,
  output logic                                 addr_valid_o,
  input  logic                                 addr_ready_i,
  output logic [ROW_ADDR_BITWIDTH-1:0]         rowAddr0_o,
  output logic [ROW_ADDR_BITWIDTH-1:0]         rowAddr1_o,
  output logic [ROW_ADDR_BITWIDTH-1:0]         rowAddr2_o,
  output logic [ROW_ADDR_BITWIDTH-1:0]         rowAddr3_o,
  output logic [ROW_ADDR_BITWIDTH-1:0]         rowAddr4_o,
  output logic [MODE_BITWIDTH-1:0]             modeSet_o,
  output logic [LW-1:0]                        layer_idx_o,
  output logic                                 last_beat_o,
`ifdef ROWADDR_BOUND_CHK_EN
  output logic                                 addr_oob_o,
`endif
  output logic                                 iter_done_o
);

  localparam int NB = SHARED_BANK_NUM;
  localparam int RW = ROW_ADDR_BITWIDTH;
  localparam int OW = GP2_ROW_ADDR_OFFSET_WIDTH;
  localparam int MW = MODE_BITWIDTH;
  localparam int BW = (BEATS_PER_LAYER > 1) ? $clog2(BEATS_PER_LAYER) : 1;
`ifdef ROWADDR_BOUND_CHK_EN
  localparam int SW = RW + 1;
  localparam logic [31:0] ADDR_MAX =
    32'(LAYER_NUM * BEATS_PER_LAYER * BEAT_ROW_STRIDE - 1);
`else
  localparam int SW = RW;
`endif
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS_PER_LAYER - 1);
  localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_NUM - 1);
  localparam logic [RW-1:0] STRIDE     = RW'(BEAT_ROW_STRIDE);

  logic          s2_adv, accept;
  logic [OW-1:0] off_in [NB];

  logic [BW-1:0] eff_beat, beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] eff_layer, layer_cnt_q, layer_cnt_d;
  logic [RW-1:0] eff_base, base_row_q, base_row_d;
  logic          eff_last_beat, eff_last_layer;
  logic          iter_done_q, iter_done_d;

  logic          s1_valid_q, s1_valid_d;
  logic [OW-1:0] s1_off_q [NB];
  logic [OW-1:0] s1_off_d [NB];
  logic [MW-1:0] s1_mode_q, s1_mode_d;
  logic [RW-1:0] s1_base_q, s1_base_d;
  logic [LW-1:0] s1_layer_q, s1_layer_d;
  logic          s1_last_q, s1_last_d;

  logic [SW-1:0] sum [NB];
  logic          s2_valid_q, s2_valid_d;
  logic [RW-1:0] s2_addr_q [NB];
  logic [RW-1:0] s2_addr_d [NB];
  logic [MW-1:0] s2_mode_q, s2_mode_d;
  logic [LW-1:0] s2_layer_q, s2_layer_d;
  logic          s2_last_q, s2_last_d;
`ifdef ROWADDR_BOUND_CHK_EN
  logic          s2_oob_q, s2_oob_d, oob_any;
`endif

  assign off_in[0] = OW'(rowAddr_offset0_i);
  assign off_in[1] = OW'(rowAddr_offset1_i);
  assign off_in[2] = OW'(rowAddr_offset2_i);
  assign off_in[3] = OW'(rowAddr_offset3_i);
  assign off_in[4] = OW'(rowAddr_offset4_i);

  assign s2_adv       = ~s2_valid_q | addr_ready_i;
  assign rqst_ready_o = ~s1_valid_q | s2_adv;
  assign accept       = rqst_valid_i & rqst_ready_o;

  // layer_start_i restarts the count before this cycle's beat is stamped
  assign eff_beat       = layer_start_i ? '0 : beat_cnt_q;
  assign eff_layer      = layer_start_i ? '0 : layer_cnt_q;
  assign eff_base       = layer_start_i ? '0 : base_row_q;
  assign eff_last_beat  = (eff_beat == BEAT_LAST);
  assign eff_last_layer = (eff_layer == LAYER_LAST);

  always_comb begin
    beat_cnt_d  = eff_beat;
    layer_cnt_d = eff_layer;
    base_row_d  = eff_base;
    iter_done_d = 1'b0;
    if (accept) begin
      base_row_d = eff_base + STRIDE;
      if (eff_last_beat) begin
        beat_cnt_d = '0;
        if (eff_last_layer) begin
          layer_cnt_d = '0;
          base_row_d  = '0;
          iter_done_d = 1'b1;
        end else begin
          layer_cnt_d = eff_layer + LW'(1);
        end
      end else begin
        beat_cnt_d = eff_beat + BW'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_off_d   = s1_off_q;
    s1_mode_d  = s1_mode_q;
    s1_base_d  = s1_base_q;
    s1_layer_d = s1_layer_q;
    s1_last_d  = s1_last_q;
    if (rqst_ready_o) s1_valid_d = rqst_valid_i;
    if (accept) begin
      s1_off_d   = off_in;
      s1_mode_d  = modeSet_i;
      s1_base_d  = eff_base;
      s1_layer_d = eff_layer;
      s1_last_d  = eff_last_beat;
    end
  end

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      sum[k] = SW'(s1_base_q) + SW'(s1_off_q[k]);
    end
  end

`ifdef ROWADDR_BOUND_CHK_EN
  always_comb begin
    oob_any = 1'b0;
    for (int k = 0; k < NB; k++) begin
      oob_any = oob_any | sum[k][RW] | (32'(sum[k]) > ADDR_MAX);
    end
  end
`endif

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_mode_d  = s2_mode_q;
    s2_layer_d = s2_layer_q;
    s2_last_d  = s2_last_q;
`ifdef ROWADDR_BOUND_CHK_EN
    s2_oob_d   = s2_oob_q;
`endif
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv & s1_valid_q) begin
      for (int k = 0; k < NB; k++) begin
        s2_addr_d[k] = sum[k][RW-1:0];
      end
      s2_mode_d  = s1_mode_q;
      s2_layer_d = s1_layer_q;
      s2_last_d  = s1_last_q;
`ifdef ROWADDR_BOUND_CHK_EN
      s2_oob_d   = oob_any;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      layer_cnt_q <= '0;
      base_row_q  <= '0;
      iter_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_off_q    <= '{default: '0};
      s1_mode_q   <= '0;
      s1_base_q   <= '0;
      s1_layer_q  <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '{default: '0};
      s2_mode_q   <= '0;
      s2_layer_q  <= '0;
      s2_last_q   <= 1'b0;
`ifdef ROWADDR_BOUND_CHK_EN
      s2_oob_q    <= 1'b0;
`endif
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      layer_cnt_q <= layer_cnt_d;
      base_row_q  <= base_row_d;
      iter_done_q <= iter_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_off_q    <= s1_off_d;
      s1_mode_q   <= s1_mode_d;
      s1_base_q   <= s1_base_d;
      s1_layer_q  <= s1_layer_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_mode_q   <= s2_mode_d;
      s2_layer_q  <= s2_layer_d;
      s2_last_q   <= s2_last_d;
`ifdef ROWADDR_BOUND_CHK_EN
      s2_oob_q    <= s2_oob_d;
`endif
    end
  end

  assign addr_valid_o = s2_valid_q;
  assign rowAddr0_o   = s2_addr_q[0];
  assign rowAddr1_o   = s2_addr_q[1];
  assign rowAddr2_o   = s2_addr_q[2];
  assign rowAddr3_o   = s2_addr_q[3];
  assign rowAddr4_o   = s2_addr_q[4];
  assign modeSet_o    = s2_mode_q;
  assign layer_idx_o  = s2_layer_q;
  assign last_beat_o  = s2_last_q;
  assign iter_done_o  = iter_done_q;
`ifdef ROWADDR_BOUND_CHK_EN
  assign addr_oob_o   = s2_oob_q;
`endif

endmodule

// File: tb/tb_rowaddr_issue_pipe.sv
// Directed bench for rowaddr_issue_pipe: vector table plus
// streaming, backpressure, layer restart and reset sequences.
module tb_rowaddr_issue_pipe;

  logic       clk;
  logic       rst;
  logic       rqst_valid;
  logic       rqst_ready;
  logic [0:0] off0, off1, off3;
  logic [1:0] off2, off4;
  logic [2:0] mode_i;
  logic       layer_start;
  logic       addr_valid;
  logic       addr_ready;
  logic [7:0] ra0, ra1, ra2, ra3, ra4;
  logic [2:0] mode_o;
  logic [1:0] layer_o;
  logic       last_o;
  logic       iter_o;
`ifdef ROWADDR_BOUND_CHK_EN
  logic       oob_o;
`endif

  int checks = 0;
  int errors = 0;

  rowaddr_issue_pipe dut (
    .sys_clk           (clk),
    .rst               (rst),
    .rqst_valid_i      (rqst_valid),
    .rqst_ready_o      (rqst_ready),
    .rowAddr_offset0_i (off0),
    .rowAddr_offset1_i (off1),
    .rowAddr_offset2_i (off2),
    .rowAddr_offset3_i (off3),
    .rowAddr_offset4_i (off4),
    .modeSet_i         (mode_i),
    .layer_start_i     (layer_start),
    .addr_valid_o      (addr_valid),
    .addr_ready_i      (addr_ready),
    .rowAddr0_o        (ra0),
    .rowAddr1_o        (ra1),
    .rowAddr2_o        (ra2),
    .rowAddr3_o        (ra3),
    .rowAddr4_o        (ra4),
    .modeSet_o         (mode_o),
    .layer_idx_o       (layer_o),
    .last_beat_o       (last_o),
`ifdef ROWADDR_BOUND_CHK_EN
    .addr_oob_o        (oob_o),
`endif
    .iter_done_o       (iter_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int v, o0, o1, o2, o3, o4, md, rdy;
    int ev, a0, a1, a2, a3, a4, em, erdy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int v, input int o0, input int o1,
                       input int o2, input int o3, input int o4,
                       input int md, input int ls, input int rdy);
    rqst_valid  = v[0];
    off0        = o0[0:0];
    off1        = o1[0:0];
    off2        = o2[1:0];
    off3        = o3[0:0];
    off4        = o4[1:0];
    mode_i      = md[2:0];
    layer_start = ls[0];
    addr_ready  = rdy[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  j;
  int  bi;
  int  o4v;
  int  iters;
  int  tx;
  int  rx;
  logic       held;
  logic [7:0] h_a4;
  logic [2:0] h_md;

  initial begin
    tbl[0] = '{1,1,0,3,1,2,5,1, 0,0,0,0,0,0,0,1};
    tbl[1] = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1};
    tbl[2] = '{0,0,0,0,0,0,0,1, 1,1,0,3,1,2,5,1};
    tbl[3] = '{1,0,1,2,0,3,2,1, 0,0,0,0,0,0,0,1};
    tbl[4] = '{1,1,1,1,1,1,7,1, 0,0,0,0,0,0,0,1};
    tbl[5] = '{0,0,0,0,0,0,0,1, 1,4,5,6,4,7,2,1};
    tbl[6] = '{0,0,0,0,0,0,0,0, 1,9,9,9,9,9,7,1};
    tbl[7] = '{0,0,0,0,0,0,0,1, 1,9,9,9,9,9,7,1};
    tbl[8] = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_ra0", 32'(ra0), 0);
    chk("rst_ra1", 32'(ra1), 0);
    chk("rst_ra2", 32'(ra2), 0);
    chk("rst_ra3", 32'(ra3), 0);
    chk("rst_ra4", 32'(ra4), 0);
    chk("rst_mode", 32'(mode_o), 0);
    chk("rst_layer", 32'(layer_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_iter", 32'(iter_o), 0);
    chk("rst_rqst_ready", 32'(rqst_ready), 1);
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].o3,
            tbl[i].o4, tbl[i].md, 0, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(addr_valid), tbl[i].ev);
      chk($sformatf("tbl%0d_rdy", i), 32'(rqst_ready), tbl[i].erdy);
      chk($sformatf("tbl%0d_iter", i), 32'(iter_o), 0);
      if (tbl[i].ev != 0) begin
        chk($sformatf("tbl%0d_ra0", i), 32'(ra0), tbl[i].a0);
        chk($sformatf("tbl%0d_ra1", i), 32'(ra1), tbl[i].a1);
        chk($sformatf("tbl%0d_ra2", i), 32'(ra2), tbl[i].a2);
        chk($sformatf("tbl%0d_ra3", i), 32'(ra3), tbl[i].a3);
        chk($sformatf("tbl%0d_ra4", i), 32'(ra4), tbl[i].a4);
        chk($sformatf("tbl%0d_mode", i), 32'(mode_o), tbl[i].em);
        chk($sformatf("tbl%0d_layer", i), 32'(layer_o), 0);
        chk($sformatf("tbl%0d_last", i), 32'(last_o), 0);
      end
      tick();
    end

    // 33 beats, zero offsets except col 2 = 3
    iters = 0;
    for (int c = 0; c < 36; c++) begin
      drive(int'(c < 33), 0, 0, 3, 0, 0, 0, int'(c == 0), 1);
      @(negedge clk);
      if (c >= 2 && c <= 34) begin
        j = (c - 2) % 32;
        chk($sformatf("st%0d_valid", c - 2), 32'(addr_valid), 1);
        chk($sformatf("st%0d_ra0", c - 2), 32'(ra0), 4 * j);
        chk($sformatf("st%0d_ra2", c - 2), 32'(ra2), 4 * j + 3);
        chk($sformatf("st%0d_layer", c - 2), 32'(layer_o), j / 8);
        chk($sformatf("st%0d_last", c - 2), 32'(last_o),
            32'(j % 8 == 7));
`ifdef ROWADDR_BOUND_CHK_EN
        chk($sformatf("st%0d_oob", c - 2), 32'(oob_o), 0);
`endif
      end else begin
        chk($sformatf("st_c%0d_idle", c), 32'(addr_valid), 0);
      end
      chk($sformatf("st_c%0d_iter", c), 32'(iter_o), 32'(c == 32));
      if (iter_o) iters++;
      tick();
    end
    chk("st_iter_pulses", iters, 1);

    // backpressure: addr_ready low for 5 cycles mid-stream
    tx = 0;
    rx = 0;
    held = 1'b0;
    h_a4 = '0;
    h_md = '0;
    for (int c = 0; c < 60 && rx < 12; c++) begin
      drive(int'(tx < 12), 0, 0, 0, 0, tx % 4, tx % 8, int'(tx == 0),
            int'(!(c >= 4 && c < 9)));
      @(negedge clk);
      if (c >= 4 && c < 9)
        chk($sformatf("bp_c%0d_rqst_ready", c), 32'(rqst_ready), 0);
      if (held) begin
        chk($sformatf("bp_c%0d_hold_valid", c), 32'(addr_valid), 1);
        chk($sformatf("bp_c%0d_hold_ra4", c), 32'(ra4), 32'(h_a4));
        chk($sformatf("bp_c%0d_hold_mode", c), 32'(mode_o), 32'(h_md));
      end
      held = addr_valid & ~addr_ready;
      h_a4 = ra4;
      h_md = mode_o;
      if (addr_valid && addr_ready) begin
        chk($sformatf("bp%0d_ra0", rx), 32'(ra0), 4 * rx);
        chk($sformatf("bp%0d_ra4", rx), 32'(ra4), 4 * rx + rx % 4);
        chk($sformatf("bp%0d_mode", rx), 32'(mode_o), rx % 8);
        chk($sformatf("bp%0d_layer", rx), 32'(layer_o), rx / 8);
        rx++;
      end
      if (rqst_valid && rqst_ready) tx++;
      tick();
    end
    chk("bp_beats_out", rx, 12);
    chk("bp_beats_in", tx, 12);

    // layer_start with an accept at beat 5 of layer 2 (beat index 21)
    for (int c = 0; c < 25; c++) begin
      o4v = (c == 21) ? 2 : ((c == 22) ? 1 : 0);
      drive(int'(c < 23), 0, 0, 0, 0, o4v, 0,
            int'(c == 0 || c == 21), 1);
      @(negedge clk);
      chk($sformatf("ls_c%0d_valid", c), 32'(addr_valid), 32'(c >= 2));
      bi = c - 2;
      if (bi == 7 || bi == 15 || bi == 20) begin
        chk($sformatf("ls%0d_ra0", bi), 32'(ra0), 4 * bi);
        chk($sformatf("ls%0d_layer", bi), 32'(layer_o), bi / 8);
        chk($sformatf("ls%0d_last", bi), 32'(last_o),
            32'(bi % 8 == 7));
      end
      if (bi == 21) begin
        chk("ls21_ra4", 32'(ra4), 2);
        chk("ls21_ra0", 32'(ra0), 0);
        chk("ls21_layer", 32'(layer_o), 0);
        chk("ls21_last", 32'(last_o), 0);
      end
      if (bi == 22) begin
        chk("ls22_ra4", 32'(ra4), 5);
        chk("ls22_ra0", 32'(ra0), 4);
        chk("ls22_layer", 32'(layer_o), 0);
      end
      tick();
    end

    // reset with beats in flight
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("mr_valid0", 32'(addr_valid), 0);
    chk("mr_ra0_clear", 32'(ra0), 0);
    chk("mr_iter", 32'(iter_o), 0);
    chk("mr_rqst_ready", 32'(rqst_ready), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("mr_valid1", 32'(addr_valid), 0);
    tick();
    @(negedge clk);
    chk("mr_valid2", 32'(addr_valid), 1);
    chk("mr_ra0", 32'(ra0), 1);
    chk("mr_layer", 32'(layer_o), 0);
    chk("mr_last", 32'(last_o), 0);
    tick();
    @(negedge clk);
    chk("mr_drained", 32'(addr_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
